// File: rtl/bpm_tracker_pkg.sv
// Shared types and elaboration-time helpers for the BPM tracker.
// Covers the FSM state encoding, the 32-bit interval type and the cycle-count / clamp helpers.
package bpm_tracker_pkg;

  typedef logic [31:0] interval_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TIMING = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  function automatic interval_t cycles_per_minute(input int unsigned clock_freq);
    logic [63:0] prod;
    prod = 64'd60 * 64'(clock_freq);
    return prod[31:0];
  endfunction

  // Minimum spacing between accepted beats, i.e. one beat period at the top tempo.
  function automatic interval_t refract_cycles(input int unsigned clock_freq,
                                               input int unsigned max_bpm);
    return cycles_per_minute(clock_freq) / interval_t'(max_bpm);
  endfunction

  function automatic interval_t timeout_cycles(input int unsigned clock_freq,
                                               input int unsigned min_bpm);
    return cycles_per_minute(clock_freq) / interval_t'(min_bpm);
  endfunction

  function automatic interval_t clamp_bpm(input interval_t q, input interval_t lo,
                                          input interval_t hi);
    if (q < lo) begin
      return lo;
    end else if (q > hi) begin
      return hi;
    end else begin
      return q;
    end
  endfunction

endpackage

// File: rtl/bpm_tracker_seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, done pulses 33 cycles after start.
// A start while busy restarts the division with the new operands.
module seq_divider
  import bpm_tracker_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      start_i,
  input  interval_t dividend_i,
  input  interval_t divisor_i,
  output interval_t quotient_o,
  output logic      done_o
);

  interval_t   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [5:0]  bits_q, bits_d;
  logic        active_q, active_d, done_q, done_d;
  logic [32:0] trial_s, diff_s;

  // Shift-subtract step; a borrow in bit 32 means the trial remainder was smaller than the divisor.
  always_comb begin
    trial_s  = {rem_q, quo_q[31]};
    diff_s   = trial_s - {1'b0, dvs_q};
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    bits_d   = bits_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (start_i) begin
      quo_d    = dividend_i;
      rem_d    = 32'd0;
      dvs_d    = divisor_i;
      bits_d   = 6'd32;
      active_d = 1'b1;
    end else if (active_q) begin
      if (bits_q != 6'd0) begin
        quo_d  = {quo_q[30:0], ~diff_s[32]};
        rem_d  = diff_s[32] ? trial_s[31:0] : diff_s[31:0];
        bits_d = bits_q - 6'd1;
      end else begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      dvs_q    <= 32'd0;
      bits_q   <= 6'd0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      bits_q   <= bits_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = done_q;

endmodule

// File: rtl/bpm_tracker.sv
// Beat-to-tempo tracker: refractory beat filter, interval timer and divider-based BPM estimate.
// Define BPM_TRACKER_AVG_EN to divide by the mean of the last four intervals instead of the latest.
module bpm_tracker
  import bpm_tracker_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 25_000_000,
  parameter int unsigned MIN_BPM    = 40,
  parameter int unsigned MAX_BPM    = 200,
  parameter int unsigned BPM_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 beat_in,
  output logic                 beat_trigger,
  output logic [BPM_WIDTH-1:0] bpm_estimate,
  output logic                 bpm_valid,
  output logic                 busy
);

  localparam interval_t REFRACT  = refract_cycles(CLOCK_FREQ, MAX_BPM);
  localparam interval_t TIMEOUT  = timeout_cycles(CLOCK_FREQ, MIN_BPM);
  localparam interval_t DIVIDEND = cycles_per_minute(CLOCK_FREQ);
  localparam interval_t MIN_Q    = interval_t'(MIN_BPM);
  localparam interval_t MAX_Q    = interval_t'(MAX_BPM);

  state_e               state_q, state_d;
  logic                 beat_prev_q, trig_q, busy_q, valid_q, valid_d;
  logic                 pend_q, pend_d;
  interval_t            cnt_q, cnt_d, pend_iv_q, pend_iv_d, new_iv_s;
  logic [BPM_WIDTH-1:0] est_q, est_d;
  logic                 accept_s, timeout_s, start_main_s, start_second_s, div_start_s;
  logic                 div_done_s, avg3_s;
  interval_t            first_dividend_s, first_divisor_s, div_dividend_s, div_divisor_s;
  interval_t            quotient_s;

  // A rising edge counts unless it falls inside the refractory window of the previous beat.
  assign accept_s  = beat_in && !beat_prev_q && ((state_q == ST_IDLE) || (cnt_q >= REFRACT));
  assign timeout_s = (state_q == ST_TIMING) && (cnt_q >= TIMEOUT) && !accept_s;
  assign new_iv_s  = accept_s ? cnt_q : pend_iv_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_DIVIDE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = accept_s ? ST_TIMING : ST_IDLE;
      ST_TIMING: begin
        if (accept_s) begin
          state_d = ST_DIVIDE;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TIMING;
        end
      end
      ST_DIVIDE: state_d = (div_done_s && !avg3_s) ? ST_UPDATE : ST_DIVIDE;
      ST_UPDATE: state_d = (pend_q || accept_s) ? ST_DIVIDE : ST_TIMING;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: divider launch and operand selection.
  always_comb begin
    start_main_s   = ((state_q == ST_TIMING) && accept_s) ||
                     ((state_q == ST_UPDATE) && (pend_q || accept_s));
    start_second_s = (state_q == ST_DIVIDE) && div_done_s && avg3_s;
    div_start_s    = start_main_s || start_second_s;
    if (start_second_s) begin
      div_dividend_s = DIVIDEND;
      div_divisor_s  = quotient_s;
    end else begin
      div_dividend_s = first_dividend_s;
      div_divisor_s  = first_divisor_s;
    end
  end

`ifdef BPM_TRACKER_AVG_EN
  interval_t [2:0] hist_q;
  logic [1:0]      nhist_q;
  logic            avg3_q, first_third_s;
  logic [33:0]     sum_s;
  logic [2:0]      count_s;

  // Mean over the new interval plus up to three stored ones; n = 3 needs a divide-by-3 pass first.
  always_comb begin
    sum_s = 34'(new_iv_s);
    if (nhist_q >= 2'd1) sum_s = sum_s + 34'(hist_q[0]); else sum_s = sum_s;
    if (nhist_q >= 2'd2) sum_s = sum_s + 34'(hist_q[1]); else sum_s = sum_s;
    if (nhist_q >= 2'd3) sum_s = sum_s + 34'(hist_q[2]); else sum_s = sum_s;
    count_s          = {1'b0, nhist_q} + 3'd1;
    first_dividend_s = DIVIDEND;
    first_divisor_s  = sum_s[31:0];
    first_third_s    = 1'b0;
    case (count_s)
      3'd1: first_divisor_s = sum_s[31:0];
      3'd2: first_divisor_s = sum_s[32:1];
      3'd3: begin
        first_dividend_s = sum_s[31:0];
        first_divisor_s  = 32'd3;
        first_third_s    = 1'b1;
      end
      default: first_divisor_s = sum_s[33:2];
    endcase
  end

  // Interval history and divide-by-3 phase flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q  <= '0;
      nhist_q <= 2'd0;
      avg3_q  <= 1'b0;
    end else if (start_main_s) begin
      hist_q  <= {hist_q[1:0], new_iv_s};
      nhist_q <= (nhist_q == 2'd3) ? 2'd3 : nhist_q + 2'd1;
      avg3_q  <= first_third_s;
    end else if (timeout_s) begin
      hist_q  <= '0;
      nhist_q <= 2'd0;
      avg3_q  <= 1'b0;
    end else if (start_second_s) begin
      avg3_q  <= 1'b0;
    end else begin
      avg3_q  <= avg3_q;
    end
  end

  assign avg3_s = avg3_q;
`else
  // Latest interval is the divisor directly.
  always_comb begin
    first_dividend_s = DIVIDEND;
    first_divisor_s  = new_iv_s;
  end

  assign avg3_s = 1'b0;
`endif

  // Interval counter, pending beat capture and estimate/valid next-state.
  always_comb begin
    cnt_d     = accept_s ? 32'd1 : ((cnt_q >= TIMEOUT) ? TIMEOUT : cnt_q + 32'd1);
    pend_d    = pend_q;
    pend_iv_d = pend_iv_q;
    est_d     = est_q;
    valid_d   = valid_q;
    if ((state_q == ST_UPDATE) && start_main_s) begin
      pend_d = 1'b0;
    end else if ((state_q == ST_DIVIDE || state_q == ST_UPDATE) && accept_s) begin
      pend_d    = 1'b1;
      pend_iv_d = cnt_q;
    end else begin
      pend_d = pend_q;
    end
    if (state_q == ST_UPDATE) begin
      est_d   = BPM_WIDTH'(clamp_bpm(quotient_s, MIN_Q, MAX_Q));
      valid_d = 1'b1;
    end else if (timeout_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_prev_q <= 1'b0;
      trig_q      <= 1'b0;
      cnt_q       <= 32'd0;
      pend_q      <= 1'b0;
      pend_iv_q   <= 32'd0;
      est_q       <= BPM_WIDTH'(MIN_BPM);
      valid_q     <= 1'b0;
    end else begin
      beat_prev_q <= beat_in;
      trig_q      <= accept_s;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_iv_q   <= pend_iv_d;
      est_q       <= est_d;
      valid_q     <= valid_d;
    end
  end

  seq_divider u_div (
    .clk_i      (clk),
    .rst_i      (reset),
    .start_i    (div_start_s),
    .dividend_i (div_dividend_s),
    .divisor_i  (div_divisor_s),
    .quotient_o (quotient_s),
    .done_o     (div_done_s)
  );

  assign beat_trigger = trig_q;
  assign bpm_estimate = est_q;
  assign bpm_valid    = valid_q;
  assign busy         = busy_q;

endmodule
